// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: one fetch in flight, PC in -> memory read -> instruction held until consumed.
// Optional YSYX_24100005_IFU_ALIGN_CHECK_EN faults misaligned PCs without issuing a memory request.
module ysyx_24100005_ifu #(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter logic [7:0]  TIMEOUT = 8'd255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    output logic              pc_ready,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              inst_fault,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    input  logic              mem_rsp_err
);

    // state | meaning
    // IDLE  | ready for a new pc
    // REQ   | read request presented, waiting for acceptance
    // WAIT  | request accepted, waiting for response or timeout
    // DONE  | inst/inst_fault valid until the core consumes them
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state;
    logic [7:0]        timer;
    logic [ADDR_W-1:0] addr_q;
    logic              misaligned;

`ifdef YSYX_24100005_IFU_ALIGN_CHECK_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign mem_req_addr = addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pc_ready      <= 1'b1;
            mem_req_valid <= 1'b0;
            inst_valid    <= 1'b0;
            inst          <= '0;
            inst_fault    <= 1'b0;
            addr_q        <= '0;
            timer         <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pc_valid) begin
                        pc_ready <= 1'b0;
                        if (misaligned) begin
                            inst       <= '0;
                            inst_fault <= 1'b1;
                            inst_valid <= 1'b1;
                            state      <= DONE;
                        end else begin
                            addr_q        <= pc;
                            mem_req_valid <= 1'b1;
                            state         <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        timer         <= 8'd0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    // a response arriving on the timeout cycle takes priority
                    if (mem_rsp_valid) begin
                        inst       <= mem_rsp_err ? '0 : mem_rsp_data;
                        inst_fault <= mem_rsp_err;
                        inst_valid <= 1'b1;
                        state      <= DONE;
                    end else if (timer == TIMEOUT - 8'd1) begin
                        inst       <= '0;
                        inst_fault <= 1'b1;
                        inst_valid <= 1'b1;
                        state      <= DONE;
                    end else if (timer != 8'hFF) begin
                        timer <= timer + 8'd1;
                    end
                end
                DONE: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        pc_ready   <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Directed bench for ysyx_24100005_ifu (TIMEOUT=4); covers both YSYX_24100005_IFU_ALIGN_CHECK_EN builds.
module tb_ysyx_24100005_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        inst_fault;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;

    int total = 0;
    int bad   = 0;
    int n_acc = 0;

    ysyx_24100005_ifu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8'd4)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .pc_ready      (pc_ready),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_fault    (inst_fault),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err)
    );

    always #5 clk = ~clk;

    // request handshakes, observed mid-cycle
    always @(negedge clk)
        if (!rst && mem_req_valid && mem_req_ready) n_acc++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; pc = '0; pc_valid = 1'b0; inst_ready = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;

        // reset
        tick(); tick();
        rst = 1'b0;
        chk("rst_pc_ready", pc_ready, 1);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_fault", inst_fault, 0);
        chk("rst_addr", mem_req_addr, 0);

        // minimum-latency fetch
        pc = 32'h8000_0000; pc_valid = 1'b1; mem_req_ready = 1'b1;
        tick();
        pc_valid = 1'b0;
        chk("t2_pc_ready", pc_ready, 0);
        chk("t2_req_valid", mem_req_valid, 1);
        chk("t2_req_addr", mem_req_addr, 32'h8000_0000);
        tick();
        chk("t2_req_drop", mem_req_valid, 0);
        chk("t2_not_yet", inst_valid, 0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0010_0093;
        tick();
        mem_rsp_valid = 1'b0;
        chk("t2_inst_valid", inst_valid, 1);
        chk("t2_inst", inst, 32'h0010_0093);
        chk("t2_fault", inst_fault, 0);
        chk("t2_no_pc_ready", pc_ready, 0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("t2_consumed", inst_valid, 0);
        chk("t2_back_idle", pc_ready, 1);

        // request backpressure, stray response in REQ, consumer backpressure
        mem_req_ready = 1'b0; pc = 32'h8000_0004; pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0; pc = 32'h1234_5678;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_BAD0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_req_hold", mem_req_valid, 1);
            chk("t3_addr_hold", mem_req_addr, 32'h8000_0004);
        end
        chk("t3_stray_rsp", inst, 32'h0010_0093);
        chk("t3_stray_valid", inst_valid, 0);
        mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("t3_req_drop", mem_req_valid, 0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0513;
        tick();
        mem_rsp_valid = 1'b0;
        chk("t3_inst", inst, 32'h0000_0513);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_valid_hold", inst_valid, 1);
            chk("t3_inst_hold", inst, 32'h0000_0513);
            chk("t3_no_pc_ready", pc_ready, 0);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("t3_idle", pc_ready, 1);
        chk("t3_consumed", inst_valid, 0);
        chk("t3_one_accept", n_acc, 2);

        // error response, then clean fetch clears fault
        mem_req_ready = 1'b1; pc = 32'h8000_0008; pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_err = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
        tick();
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        chk("t4_err_inst", inst, 0);
        chk("t4_err_fault", inst_fault, 1);
        chk("t4_err_valid", inst_valid, 1);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        pc = 32'h8000_000C; pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0013;
        tick();
        mem_rsp_valid = 1'b0;
        chk("t4_ok_inst", inst, 32'h0000_0013);
        chk("t4_ok_fault", inst_fault, 0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;

        // timeout after 4 WAIT cycles, late response ignored
        pc = 32'h8000_0010; pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        tick();
        tick(); tick(); tick();
        chk("t5_not_timed_out", inst_valid, 0);
        tick();
        chk("t5_to_valid", inst_valid, 1);
        chk("t5_to_fault", inst_fault, 1);
        chk("t5_to_inst", inst, 0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
        tick();
        chk("t5_late_inst", inst, 0);
        chk("t5_late_fault", inst_fault, 1);
        mem_rsp_valid = 1'b0; inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        chk("t5_idle_rsp_inst", inst, 0);
        chk("t5_idle_rsp_fault", inst_fault, 1);
        chk("t5_idle_rsp_valid", inst_valid, 0);

        // reset while in WAIT
        pc = 32'h8000_0014; pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_pc_ready", pc_ready, 1);
        chk("t6_rst_fault", inst_fault, 0);
        chk("t6_rst_addr", mem_req_addr, 0);
        chk("t6_rst_req", mem_req_valid, 0);
        chk("t6_rst_valid", inst_valid, 0);
        chk("t6_rst_inst", inst, 0);

        // misaligned pc
        pc = 32'h8000_0002; pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
`ifdef YSYX_24100005_IFU_ALIGN_CHECK_EN
        chk("t6_al_no_req", mem_req_valid, 0);
        chk("t6_al_valid", inst_valid, 1);
        chk("t6_al_fault", inst_fault, 1);
        chk("t6_al_inst", inst, 0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("t6_al_idle", pc_ready, 1);
        chk("t6_accepts", n_acc, 6);
`else
        chk("t6_na_req", mem_req_valid, 1);
        chk("t6_na_addr", mem_req_addr, 32'h8000_0002);
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0073;
        tick();
        mem_rsp_valid = 1'b0;
        chk("t6_na_inst", inst, 32'h0000_0073);
        chk("t6_na_fault", inst_fault, 0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("t6_na_idle", pc_ready, 1);
        chk("t6_accepts", n_acc, 7);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
